// File: rtl/wb_port_arbiter_pkg.sv
// Shared writeback-port definitions: holding depth, starvation limit, $0 index and entry record.
// Latency: none (constants and types only).
// Backpressure: none.
package wb_port_arbiter_pkg;

    localparam int FIFO_DEPTH = 2;
    localparam int STARVE_LIMIT = 4;
    localparam logic [4:0] REG_ZERO = 5'd0;

    // One buffered MDU result; live drops to 0 when a younger pipeline write to the same register wins.
    typedef struct packed {
        logic [4:0]  dest;
        logic [31:0] data;
        logic        live;
    } wbEntry_t;

endpackage

// File: rtl/wb_fifo2.sv
// Small in-order holding queue for MDU results with kill-by-destination.
// Latency: a pushed entry is visible at the head the cycle after the push (no bypass).
// Backpressure: caller must only push when count < DEPTH; a push while full is ignored.
module wb_fifo2
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  wbEntry_t                     pushEntry,
    input  logic                         pop,
    input  logic                         kill,
    input  logic [4:0]                   killDest,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output wbEntry_t                     head
);

    localparam int CW = $clog2(DEPTH + 1);

    wbEntry_t       mem [DEPTH];
    wbEntry_t       killed [DEPTH];
    wbEntry_t       memNext [DEPTH];
    logic [CW-1:0]  countNext;

    assign head = mem[0];

    // Kill matching live entries first, then shift on pop, then append the new entry so it is never killed.
    always_comb begin
        killed    = mem;
        memNext   = mem;
        countNext = count;
        for (int i = 0; i < DEPTH; i++) begin
            if (kill && mem[i].live && (mem[i].dest == killDest)) begin
                killed[i].live = 1'b0;
            end
        end
        memNext = killed;
        if (pop && (count != '0)) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                memNext[i] = killed[i + 1];
            end
            memNext[DEPTH - 1].live = 1'b0;
            countNext = count - CW'(1);
        end
        if (push && (count < CW'(DEPTH))) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i == int'(countNext)) begin
                    memNext[i] = pushEntry;
                end
            end
            countNext = countNext + CW'(1);
        end
    end

    // Storage and occupancy; reset empties the queue and marks every slot dead.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            count <= countNext;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= memNext[i];
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between the W-stage pipeline and buffered MDU results.
// Latency: rf_* registered, one cycle after the grant; MDU results earliest one cycle after push.
// Backpressure: mdu_ready drops when the holding queue is full; StallW freezes M/W when a starved result is forced.
module wb_port_arbiter #(
    parameter int FIFO_DEPTH = wb_port_arbiter_pkg::FIFO_DEPTH,
    parameter int STARVE_LIMIT = wb_port_arbiter_pkg::STARVE_LIMIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteW,
    input  logic [4:0]  WriteRegW,
    input  logic [31:0] ResultW,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_dest,
    input  logic [31:0] mdu_result,
    output logic        mdu_ready,
    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd,
    output logic        StallW
);

    import wb_port_arbiter_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] count;
    wbEntry_t      head;
    wbEntry_t      pushEntry;
    logic [SW-1:0] starve;
    logic          fifoEmpty;
    logic          fifoFull;
    logic          pipeReq;
    logic          mduPush;
    logic          grantFifo;
    logic          grantPipe;

    assign fifoEmpty = (count == '0);
    assign fifoFull  = (count == CW'(FIFO_DEPTH));
    assign mdu_ready = !rst && !fifoFull;
    assign mduPush   = mdu_valid && mdu_ready;
    assign pipeReq   = RegWriteW && (WriteRegW != REG_ZERO);
    assign pushEntry = '{dest: mdu_dest, data: mdu_result, live: 1'b1};

    // Grant selection: a starved head beats the pipeline (and stalls it), otherwise the pipeline wins.
    always_comb begin
        grantFifo = 1'b0;
        grantPipe = 1'b0;
        StallW    = 1'b0;
        if (!rst) begin
            if (!fifoEmpty && (starve == SW'(STARVE_LIMIT))) begin
                grantFifo = 1'b1;
                StallW    = 1'b1;
            end else if (pipeReq) begin
                grantPipe = 1'b1;
            end else if (!fifoEmpty) begin
                grantFifo = 1'b1;
            end
        end
    end

    wb_fifo2 #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (mduPush),
        .pushEntry(pushEntry),
        .pop      (grantFifo),
        .kill     (grantPipe),
        .killDest (WriteRegW),
        .count    (count),
        .head     (head)
    );

    // Starvation counter: counts cycles a waiting head is passed over, saturating at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve <= '0;
        end else if (fifoEmpty || grantFifo) begin
            starve <= '0;
        end else if (starve != SW'(STARVE_LIMIT)) begin
            starve <= starve + SW'(1);
        end
    end

    // Registered write port; dead or $0 entries still consume their grant but do not write.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we <= 1'b0;
            rf_wa <= '0;
            rf_wd <= '0;
        end else if (grantFifo) begin
            rf_we <= head.live && (head.dest != REG_ZERO);
            rf_wa <= head.dest;
            rf_wd <= head.data;
        end else if (grantPipe) begin
            rf_we <= 1'b1;
            rf_wa <= WriteRegW;
            rf_wd <= ResultW;
        end else begin
            rf_we <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: directed scenarios then randomized traffic vs a queue-based model.
// Latency: expected write-port values are queued per cycle and checked one edge later by the monitor.
// Backpressure: the MDU driver holds each offer until the model says it was accepted.
module tb_wb_port_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    typedef struct packed {
        logic [4:0]  dest;
        logic [31:0] data;
        logic        live;
    } mEnt_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
    } expT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        RegWriteW = 1'b0;
    logic [4:0]  WriteRegW = '0;
    logic [31:0] ResultW = '0;
    logic        mdu_valid = 1'b0;
    logic [4:0]  mdu_dest = '0;
    logic [31:0] mdu_result = '0;
    logic        mdu_ready;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        StallW;

    int errors = 0;
    int checks = 0;

    // Reference model state
    mEnt_t       mq[$];
    int          starve = 0;
    logic [4:0]  lastWa = '0;
    logic [31:0] lastWd = '0;
    bit          modelStall = 0;
    bit          dutStall = 0;
    expT         expQ[$];
    logic [31:0] dutRf [32] = '{default: 32'd0};

    always #5 clk = ~clk;

    wb_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .RegWriteW (RegWriteW),
        .WriteRegW (WriteRegW),
        .ResultW   (ResultW),
        .mdu_valid (mdu_valid),
        .mdu_dest  (mdu_dest),
        .mdu_result(mdu_result),
        .mdu_ready (mdu_ready),
        .rf_we     (rf_we),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd),
        .StallW    (StallW)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    // One cycle: drive inputs, check combinational outputs, advance the model, queue the registered result.
    task automatic step(input bit r, input bit rw, input logic [4:0] wr, input logic [31:0] res,
                        input bit mv, input logic [4:0] md, input logic [31:0] mr, output bit acc);
        bit  expReady, expStall, gFifo, gPipe, wasEmpty;
        mEnt_t h;
        expT e;
        @(negedge clk);
        rst = r; RegWriteW = rw; WriteRegW = wr; ResultW = res;
        mdu_valid = mv; mdu_dest = md; mdu_result = mr;
        #1;
        acc = 0; gFifo = 0; gPipe = 0; expStall = 0; expReady = 0;
        if (!r) begin
            expReady = (mq.size() < DEPTH);
            if (mq.size() > 0 && starve == LIMIT) begin
                gFifo = 1; expStall = 1;
            end else if (rw && wr != 5'd0) begin
                gPipe = 1;
            end else if (mq.size() > 0) begin
                gFifo = 1;
            end
        end
        check("mdu_ready", {31'd0, mdu_ready}, {31'd0, expReady});
        check("StallW", {31'd0, StallW}, {31'd0, expStall});
        dutStall = StallW;
        modelStall = expStall;
        if (r) begin
            mq.delete();
            starve = 0;
            e = '0;
        end else begin
            wasEmpty = (mq.size() == 0);
            if (gFifo) begin
                h = mq.pop_front();
                e.we = h.live && (h.dest != 5'd0);
                e.wa = h.dest;
                e.wd = h.data;
            end else if (gPipe) begin
                e.we = 1'b1; e.wa = wr; e.wd = res;
                foreach (mq[i]) if (mq[i].live && mq[i].dest == wr) mq[i].live = 1'b0;
            end else begin
                e.we = 1'b0; e.wa = lastWa; e.wd = lastWd;
            end
            starve = (wasEmpty || gFifo) ? 0 : ((starve < LIMIT) ? starve + 1 : LIMIT);
            if (mv && expReady) begin
                mq.push_back('{dest: md, data: mr, live: 1'b1});
                acc = 1;
            end
        end
        lastWa = e.wa;
        lastWd = e.wd;
        expQ.push_back(e);
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, a);
    endtask

    // Monitor: compares every registered write-port sample against the queued expectation.
    expT mon;
    always @(posedge clk) begin
        #1;
        if (expQ.size() > 0) begin
            mon = expQ.pop_front();
            check("rf_we", {31'd0, rf_we}, {31'd0, mon.we});
            check("rf_wa", {27'd0, rf_wa}, {27'd0, mon.wa});
            check("rf_wd", rf_wd, mon.wd);
            if (rf_we === 1'b1) dutRf[rf_wa] = rf_wd;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit a;
        bit offV;
        logic [4:0]  offD, pWr;
        logic [31:0] offR, pRes;
        bit pRw;

        // Reset state
        for (int i = 0; i < 3; i++) step(1, 0, 5'd0, 32'd0, 1, 5'd3, 32'h3, a);

        // Idle pipeline: a pushed result writes the cycle after
        step(0, 0, 5'd0, 32'd0, 1, 5'd5, 32'h11, a);
        idle(3);
        check("r5_after_push", dutRf[5], 32'h11);

        // Starvation under continuous pipeline writes
        step(0, 1, 5'd3, 32'h33, 1, 5'd7, 32'h77, a);
        for (int i = 1; i <= 7; i++) begin
            step(0, 1, 5'd3, 32'h33, 0, 5'd0, 32'd0, a);
            check("stall_cycle", {31'd0, dutStall}, (i == 5) ? 32'd1 : 32'd0);
        end
        idle(2);
        check("r7_forced", dutRf[7], 32'h77);

        // Backpressure: third offer held until a pop frees a slot
        step(0, 1, 5'd4, 32'h44, 1, 5'd10, 32'hA0, a);
        step(0, 1, 5'd4, 32'h44, 1, 5'd11, 32'hA1, a);
        offV = 1;
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 5'd4, 32'h44, offV, 5'd12, 32'hA2, a);
            if (a) offV = 0;
        end
        idle(5);
        check("r12_after_hold", dutRf[12], 32'hA2);

        // WAW: the younger pipeline write kills the buffered one
        step(0, 1, 5'd2, 32'h22, 1, 5'd9, 32'h99, a);
        step(0, 1, 5'd9, 32'hAA, 0, 5'd0, 32'd0, a);
        idle(3);
        check("r9_waw", dutRf[9], 32'hAA);

        // $0 rules
        step(0, 1, 5'd0, 32'h55, 1, 5'd6, 32'h66, a);
        step(0, 1, 5'd0, 32'h55, 0, 5'd0, 32'd0, a);
        step(0, 0, 5'd0, 32'd0, 1, 5'd0, 32'h12, a);
        idle(2);
        check("r6_drained", dutRf[6], 32'h66);
        check("r0_untouched", dutRf[0], 32'd0);

        // Reset in a would-be stall cycle discards the pending entry
        step(0, 1, 5'd3, 32'h34, 1, 5'd13, 32'hDD, a);
        for (int i = 0; i < 4; i++) step(0, 1, 5'd3, 32'h34, 0, 5'd0, 32'd0, a);
        step(1, 1, 5'd3, 32'h34, 1, 5'd14, 32'hEE, a);
        check("stall_in_reset", {31'd0, dutStall}, 32'd0);
        step(1, 0, 5'd0, 32'd0, 1, 5'd14, 32'hEE, a);
        idle(3);
        check("r13_discarded", dutRf[13], 32'd0);

        // Randomized traffic
        offV = 0; offD = '0; offR = '0;
        pRw = 0; pWr = '0; pRes = '0;
        for (int n = 0; n < 800; n++) begin
            if (!offV && $urandom_range(0, 1) == 1) begin
                offV = 1;
                offD = 5'($urandom_range(0, 11));
                offR = $urandom;
            end
            if (!modelStall) begin
                pRw  = ($urandom_range(0, 3) != 0);
                pWr  = 5'($urandom_range(0, 11));
                pRes = $urandom;
            end
            step(($urandom_range(0, 149) == 0), pRw, pWr, pRes, offV, offD, offR, a);
            if (a) offV = 0;
        end
        idle(4);

        @(posedge clk);
        #2;
        check("scoreboard_drained", expQ.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
